dlx_mem_seq: RTL and testbench
==============================

Name: dlx_mem_seq

Overview:
Data-memory access sequencer between the DLX decode/execute stage and a word-wide, request/acknowledge data memory.
- Accepts one load or store per request using the decoder's mem_to_reg, mem_wr, lb, lh, sb, sh and load_extend signals.
- Performs aligned word transfers directly.
- Implements SB/SH as read-modify-write.
- Extracts and extends LB/LH/LBU/LHU data.
- Stalls the pipeline until the access completes or times out.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before abort (>=2)
CNT_W, 5, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  access request, held by pipeline until done
req_rd  in  1  load (decoder mem_to_reg)
req_wr  in  1  store (decoder mem_wr)
req_lb  in  1  byte load
req_lh  in  1  halfword load
req_sb  in  1  byte store
req_sh  in  1  halfword store
req_sext  in  1  sign-extend sub-word load (decoder load_extend)
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, sub-word in LSBs
stall  out  1  req_valid & ~done, combinational
done  out  1  one-cycle completion pulse
err  out  1  valid with done: misaligned, illegal or timeout
rdata  out  32  load result, held until the next load completes
mem_req  out  1  memory request, registered
mem_we  out  1  write enable, registered
mem_addr  out  32  word address, {req_addr[31:2],2'b00}, registered
mem_wdata  out  32  write word, registered
mem_rdata  in  32  read word, valid with mem_ack on a read
mem_ack  in  1  memory accept/complete; may be high in the first mem_req cycle

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; mem_req, mem_we, done and err = 0; mem_addr, mem_wdata and rdata = 0; counter = 0.
- Reset is honoured in any state. An in-flight mem_req drops at that edge. No done is issued for the abandoned access.
- Byte order is big-endian: addr[1:0]=0 selects bits 31:24; a halfword with addr[1]=0 selects bits 31:16.
- States: IDLE, READ, WRITE, RMW_RD, RMW_WR, DONE.
- IDLE with req_valid: classify the request.
  - Misaligned: lh/sh with addr[0]=1, or word access with addr[1:0]!=0.
  - Illegal: req_rd & req_wr, or neither set.
  - Misaligned or illegal -> DONE with err=1; no memory access.
  - Load -> READ. Word store -> WRITE. sb/sh -> RMW_RD.
  - mem_req, mem_we, mem_addr and mem_wdata are registered on the transition edge.
- READ / RMW_RD / WRITE: mem_req=1, with address/data/we stable until mem_ack is sampled high.
  - On ack, READ latches the extracted rdata and goes to DONE.
  - On ack, RMW_RD merges the sub-word into mem_rdata, loads mem_wdata and goes to RMW_WR with mem_we=1.
  - On ack, WRITE goes to DONE.
- RMW_WR: same handshake as WRITE; on ack -> DONE.
- mem_req deasserts on the edge at which ack is sampled, except the RMW_RD->RMW_WR edge, where it stays high with mem_we rising.
- Timeout: the counter clears on entering any request state and increments each cycle mem_req=1 & mem_ack=0.
  - When it reaches TIMEOUT-1 with no ack: drop mem_req, go to DONE with err=1, leave rdata unchanged.
  - A timed-out RMW never issues its write.
- DONE: done=1 for exactly one cycle, err as determined; then IDLE unconditionally. req_valid is ignored in DONE, so the next request starts the following cycle.
- mem_ack in IDLE or DONE is ignored.
- Latency with zero-wait memory, counted from the req_valid cycle to the done cycle:
  - load / SW: 2 cycles.
  - SB/SH: 3 cycles.
  - misaligned/illegal: 1 cycle.
- Load extraction:
  - lb: selected byte, sign-extended if req_sext, else zero-extended.
  - lh: selected halfword, extended the same way.
  - word: unmodified.
- Store merge: sb replaces the addressed byte lane with req_wdata[7:0]; sh replaces the addressed halfword with req_wdata[15:0]; other lanes keep mem_rdata.

Decomposition:
- Package dlx_mem_pkg holds:
  - the state enum;
  - lane index constants (BYTE0_HI=31 ...);
  - a TIMEOUT default constant.
- Sub-module dlx_mem_lane is purely combinational:
  - inputs: addr[1:0], lb/lh/sext, sb/sh, read word, store data;
  - outputs: extracted load value and merged store word.
- The sequencer FSM and counter remain in dlx_mem_seq.

Test Plan:
- LB, addr 0x103, sext=1, memory word 0x112233F0, ack in first cycle -> done in cycle 2, rdata=0xFFFFFFF0, err=0. Repeat with sext=0 -> rdata=0x000000F0.
- SH, addr 0x202, wdata 0x0000BEEF, memory word 0xAABBCCDD -> read, then write of 0xAABBBEEF to mem_addr 0x200; done in cycle 3.
- SW, addr 0x300, ack delayed 3 cycles -> mem_req/addr/wdata stable for 4 cycles, stall high throughout, one done pulse, mem_req low the cycle after ack.
- LW at addr 0x102, then SH at addr 0x101 -> each gives done+err in 1 cycle, mem_req never asserted.
- LW with mem_ack never asserted, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then done=1, err=1, rdata unchanged; SB under the same condition issues no write.
- rst_n low during RMW_WR -> mem_req=0 next edge, no done; a new LW issued afterwards completes normally.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_mem_pkg
//  Description : Shared types and constants for the DLX data-memory access
//                sequencer: FSM state encoding, big-endian lane positions and
//                the default request timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package dlx_mem_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Big-endian lane positions: byte offset 0 is the most significant byte.
    localparam int BYTE0_HI = 31;
    localparam int BYTE1_HI = 23;
    localparam int BYTE2_HI = 15;
    localparam int BYTE3_HI = 7;
    localparam int HALF0_HI = 31;
    localparam int HALF1_HI = 15;

    // Default number of cycles mem_req may stay unacknowledged
    localparam int TIMEOUT_DEFAULT = 16;

endpackage : dlx_mem_pkg
`default_nettype wire

// File: rtl/dlx_mem_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_mem_seq_if
//  Description : Bundle of the pipeline-side request signals and the
//                memory-side request/acknowledge bus of dlx_mem_seq.
//  Ports       : master - environment view (pipeline + data memory): drives
//                         req_* and mem_rdata/mem_ack, observes the rest.
//                slave  - sequencer view: the opposite directions.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dlx_mem_seq_if;

    // Pipeline side
    logic        req_valid;
    logic        req_rd;
    logic        req_wr;
    logic        req_lb;
    logic        req_lh;
    logic        req_sb;
    logic        req_sh;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    // Memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output req_valid, req_rd, req_wr, req_lb, req_lh, req_sb, req_sh,
               req_sext, req_addr, req_wdata,
        input  stall, done, err, rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

    modport slave (
        input  req_valid, req_rd, req_wr, req_lb, req_lh, req_sb, req_sh,
               req_sext, req_addr, req_wdata,
        output stall, done, err, rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

endinterface : dlx_mem_seq_if
`default_nettype wire

// File: rtl/dlx_mem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_mem_lane
//  Description : Combinational big-endian lane logic. Extracts and extends a
//                byte/halfword from a read word, and merges a byte/halfword
//                of store data into a read word for read-modify-write.
//  Ports       : addr_lo_i  - byte offset within the word
//                lb_i/lh_i  - byte / halfword load select
//                sext_i     - sign-extend sub-word load
//                sb_i/sh_i  - byte / halfword store select
//                rword_i    - word read from memory
//                wdata_i    - store data (sub-word in LSBs)
//                load_o     - extracted, extended load value
//                merge_o    - store word (merged for sb/sh, wdata_i otherwise)
//  Revision    : 1.0 - initial release
// ============================================================================
module dlx_mem_lane
    import dlx_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic        lb_i,
    input  logic        lh_i,
    input  logic        sext_i,
    input  logic        sb_i,
    input  logic        sh_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load extraction
    always_comb begin
        w_byte = '0;
        case (addr_lo_i)
            2'd0:    w_byte = rword_i[BYTE0_HI -: 8];
            2'd1:    w_byte = rword_i[BYTE1_HI -: 8];
            2'd2:    w_byte = rword_i[BYTE2_HI -: 8];
            default: w_byte = rword_i[BYTE3_HI -: 8];
        endcase

        w_half = addr_lo_i[1] ? rword_i[HALF1_HI -: 16] : rword_i[HALF0_HI -: 16];

        if (lb_i) begin
            load_o = {{24{sext_i & w_byte[7]}}, w_byte};
        end else if (lh_i) begin
            load_o = {{16{sext_i & w_half[15]}}, w_half};
        end else begin
            load_o = rword_i;
        end
    end

    // Store merge: only the addressed lane is replaced
    always_comb begin
        merge_o = rword_i;
        if (sb_i) begin
            case (addr_lo_i)
                2'd0:    merge_o[BYTE0_HI -: 8] = wdata_i[7:0];
                2'd1:    merge_o[BYTE1_HI -: 8] = wdata_i[7:0];
                2'd2:    merge_o[BYTE2_HI -: 8] = wdata_i[7:0];
                default: merge_o[BYTE3_HI -: 8] = wdata_i[7:0];
            endcase
        end else if (sh_i) begin
            if (addr_lo_i[1]) begin
                merge_o[HALF1_HI -: 16] = wdata_i[15:0];
            end else begin
                merge_o[HALF0_HI -: 16] = wdata_i[15:0];
            end
        end else begin
            merge_o = wdata_i;
        end
    end

endmodule : dlx_mem_lane
`default_nettype wire

// File: rtl/dlx_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_mem_seq
//  Description : DLX data-memory access sequencer. Accepts one load/store per
//                request, performs word transfers directly, byte/halfword
//                stores as read-modify-write, extracts/extends sub-word
//                loads, and stalls the pipeline until completion or timeout.
//  Ports       : clk   - clock, all state on the rising edge
//                rst_n - synchronous active-low reset
//                bus   - dlx_mem_seq_if.slave: pipeline request/stall/done
//                        signals and the memory request/acknowledge bus
//  Parameters  : TIMEOUT - max cycles mem_req may wait for mem_ack (>=2)
//                CNT_W   - timeout counter width, must hold TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module dlx_mem_seq
    import dlx_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    dlx_mem_seq_if.slave  bus
);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [31:0]        rdata_q;
    logic               done_q;
    logic               err_q;

    // Request attributes captured at acceptance for the lane logic
    logic [1:0]         addr_lo_q;
    logic               lb_q;
    logic               lh_q;
    logic               sb_q;
    logic               sh_q;
    logic               sext_q;

    // Request classification (meaningful only in IDLE)
    logic               w_is_load;
    logic               w_is_store;
    logic               w_illegal;
    logic               w_byte;
    logic               w_half;
    logic               w_word;
    logic               w_misaligned;
    logic [31:0]        w_load_val;
    logic [31:0]        w_merge_word;

    assign w_is_load    = bus.req_rd & ~bus.req_wr;
    assign w_is_store   = bus.req_wr & ~bus.req_rd;
    assign w_illegal    = ~(w_is_load | w_is_store);
    // Byte select takes precedence when both sub-word flags are set
    assign w_byte       = w_is_load ? bus.req_lb : bus.req_sb;
    assign w_half       = ~w_byte & (w_is_load ? bus.req_lh : bus.req_sh);
    assign w_word       = ~w_byte & ~w_half;
    assign w_misaligned = (w_half & bus.req_addr[0]) |
                          (w_word & (bus.req_addr[1:0] != 2'b00));

    // The store data for the lane is the captured request data held in
    // mem_wdata_q while the RMW read is outstanding.
    dlx_mem_lane u_lane (
        .addr_lo_i (addr_lo_q),
        .lb_i      (lb_q),
        .lh_i      (lh_q),
        .sext_i    (sext_q),
        .sb_i      (sb_q),
        .sh_i      (sh_q),
        .rword_i   (bus.mem_rdata),
        .wdata_i   (mem_wdata_q),
        .load_o    (w_load_val),
        .merge_o   (w_merge_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_lo_q   <= '0;
            lb_q        <= 1'b0;
            lh_q        <= 1'b0;
            sb_q        <= 1'b0;
            sh_q        <= 1'b0;
            sext_q      <= 1'b0;
        end else begin
            // done/err are single-cycle pulses
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_illegal | w_misaligned) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            addr_lo_q   <= bus.req_addr[1:0];
                            lb_q        <= w_is_load & w_byte;
                            lh_q        <= w_is_load & w_half;
                            sb_q        <= w_is_store & w_byte;
                            sh_q        <= w_is_store & w_half;
                            sext_q      <= bus.req_sext;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= w_is_store & w_word;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_wdata_q <= bus.req_wdata;
                            cnt_q       <= '0;
                            if (w_is_load) begin
                                state_q <= ST_READ;
                            end else if (w_word) begin
                                state_q <= ST_WRITE;
                            end else begin
                                state_q <= ST_RMW_RD;
                            end
                        end
                    end
                end

                ST_READ, ST_WRITE, ST_RMW_RD, ST_RMW_WR: begin
                    if (bus.mem_ack) begin
                        cnt_q <= '0;
                        if (state_q == ST_RMW_RD) begin
                            // Keep mem_req high and turn the read into the write
                            mem_wdata_q <= w_merge_word;
                            mem_we_q    <= 1'b1;
                            state_q     <= ST_RMW_WR;
                        end else begin
                            if (state_q == ST_READ) begin
                                rdata_q <= w_load_val;
                            end
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Abort: rdata untouched, a pending RMW write never issues
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stall     = bus.req_valid & ~done_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule : dlx_mem_seq
`default_nettype wire

// File: tb/tb_dlx_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dlx_mem_seq
//  Description : Self-checking bench for dlx_mem_seq. Table of directed
//                load/store vectors with a per-phase delayed-ack memory
//                responder, plus a hand-written reset-during-RMW sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dlx_mem_seq;

    logic clk;
    logic rst_n;

    dlx_mem_seq_if bus ();

    dlx_mem_seq #(
        .TIMEOUT (16),
        .CNT_W   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic        rd, wr, lb, lh, sb, sh, sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;      // word returned by memory on reads
        int          delay;      // unacked cycles per phase, -1 = never ack
        int          exp_lat;    // req_valid cycle -> done cycle
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_req;    // cycles with mem_req high
        int          exp_we;     // cycles with mem_req & mem_we high
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string n, input logic rd, input logic wr, input logic lb,
        input logic lh, input logic sb, input logic sh, input logic sext,
        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mword,
        input int delay, input int lat, input logic err, input logic [31:0] rdata,
        input int nreq, input int nwe, input logic [31:0] wword);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.lb = lb; v.lh = lh; v.sb = sb;
        v.sh = sh; v.sext = sext; v.addr = addr; v.wdata = wdata; v.mword = mword;
        v.delay = delay; v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rdata;
        v.exp_req = nreq; v.exp_we = nwe; v.exp_wword = wword;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat = -1;
        int          nreq = 0;
        int          nwe = 0;
        int          ph = 0;
        int          stall_bad = 0;
        int          unstable = 0;
        int          req_at_done = 0;
        logic        err_s = 1'b0;
        logic        prev_req = 1'b0;
        logic        prev_we = 1'b0;
        logic [31:0] rd_s = '0;
        logic [31:0] wword = '0;
        logic [31:0] waddr = '0;
        logic [31:0] raddr = '0;
        logic [31:0] ph_addr = '0;
        logic [31:0] ph_data = '0;

        bus.req_rd    = v.rd;   bus.req_wr = v.wr;
        bus.req_lb    = v.lb;   bus.req_lh = v.lh;
        bus.req_sb    = v.sb;   bus.req_sh = v.sh;
        bus.req_sext  = v.sext;
        bus.req_addr  = v.addr; bus.req_wdata = v.wdata;
        bus.mem_rdata = v.mword;
        bus.mem_ack   = 1'b0;
        bus.req_valid = 1'b1;

        for (int t = 1; t <= 40 && lat < 0; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat   = t;
                err_s = bus.err;
                rd_s  = bus.rdata;
                if (bus.mem_req) req_at_done++;
                if (bus.stall)   stall_bad++;
                bus.mem_ack = 1'b0;
            end else begin
                if (!bus.stall) stall_bad++;
                if (bus.mem_req) begin
                    nreq++;
                    if (!prev_req || (bus.mem_we && !prev_we)) begin
                        ph      = 0;
                        ph_addr = bus.mem_addr;
                        ph_data = bus.mem_wdata;
                        if (nreq == 1) raddr = bus.mem_addr;
                    end else if (bus.mem_addr !== ph_addr || bus.mem_wdata !== ph_data) begin
                        unstable++;
                    end
                    ph++;
                    if (bus.mem_we) begin
                        nwe++;
                        wword = bus.mem_wdata;
                        waddr = bus.mem_addr;
                    end
                    bus.mem_ack = (v.delay >= 0) && (ph > v.delay);
                end else begin
                    bus.mem_ack = 1'b0;
                end
                prev_req = bus.mem_req;
                prev_we  = bus.mem_we;
            end
        end

        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        @(posedge clk);
        @(negedge clk);

        chk({v.name, ".latency"},     32'(lat),        32'(v.exp_lat));
        chk({v.name, ".err"},         32'(err_s),      32'(v.exp_err));
        chk({v.name, ".rdata"},       rd_s,            v.exp_rdata);
        chk({v.name, ".req_cycles"},  32'(nreq),       32'(v.exp_req));
        chk({v.name, ".we_cycles"},   32'(nwe),        32'(v.exp_we));
        chk({v.name, ".stall"},       32'(stall_bad),  32'd0);
        chk({v.name, ".stable"},      32'(unstable),   32'd0);
        chk({v.name, ".req_at_done"}, 32'(req_at_done), 32'd0);
        chk({v.name, ".done_pulse"},  32'(bus.done),   32'd0);
        if (v.exp_req > 0) begin
            chk({v.name, ".addr"}, raddr, {v.addr[31:2], 2'b00});
        end
        if (v.exp_we > 0) begin
            chk({v.name, ".wword"}, wword, v.exp_wword);
            chk({v.name, ".waddr"}, waddr, {v.addr[31:2], 2'b00});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1);
    end

    initial begin
        int   done_seen;

        //           name        rd wr lb lh sb sh sx addr          wdata         mword         dly lat err rdata         req we wword
        vecs.push_back(mk("lb_sx",    1,0,1,0,0,0,1, 32'h103, 32'h0,        32'h112233F0, 0,  2,  0, 32'hFFFFFFF0, 1, 0, 32'h0));
        vecs.push_back(mk("lb_zx",    1,0,1,0,0,0,0, 32'h103, 32'h0,        32'h112233F0, 0,  2,  0, 32'h000000F0, 1, 0, 32'h0));
        vecs.push_back(mk("lb_b1",    1,0,1,0,0,0,1, 32'h101, 32'h0,        32'h11823344, 0,  2,  0, 32'hFFFFFF82, 1, 0, 32'h0));
        vecs.push_back(mk("lh_sx",    1,0,0,1,0,0,1, 32'h102, 32'h0,        32'h12348001, 0,  2,  0, 32'hFFFF8001, 1, 0, 32'h0));
        vecs.push_back(mk("lh_zx",    1,0,0,1,0,0,0, 32'h100, 32'h0,        32'h9ABC1234, 0,  2,  0, 32'h00009ABC, 1, 0, 32'h0));
        vecs.push_back(mk("lw_wait2", 1,0,0,0,0,0,0, 32'h104, 32'h0,        32'hDEADBEEF, 2,  4,  0, 32'hDEADBEEF, 3, 0, 32'h0));
        vecs.push_back(mk("sh_lo",    0,1,0,0,0,1,0, 32'h202, 32'h0000BEEF, 32'hAABBCCDD, 0,  3,  0, 32'hDEADBEEF, 2, 1, 32'hAABBBEEF));
        vecs.push_back(mk("sh_hi",    0,1,0,0,0,1,0, 32'h200, 32'h00001234, 32'hAABBCCDD, 0,  3,  0, 32'hDEADBEEF, 2, 1, 32'h1234CCDD));
        vecs.push_back(mk("sb_b1",    0,1,0,0,1,0,0, 32'h205, 32'h12345677, 32'hAABBCCDD, 0,  3,  0, 32'hDEADBEEF, 2, 1, 32'hAA77CCDD));
        vecs.push_back(mk("sb_b3",    0,1,0,0,1,0,0, 32'h203, 32'h000000EE, 32'hAABBCCDD, 0,  3,  0, 32'hDEADBEEF, 2, 1, 32'hAABBCCEE));
        vecs.push_back(mk("sw_wait3", 0,1,0,0,0,0,0, 32'h300, 32'hCAFEF00D, 32'h0,        3,  5,  0, 32'hDEADBEEF, 4, 4, 32'hCAFEF00D));
        vecs.push_back(mk("lw_mis",   1,0,0,0,0,0,0, 32'h102, 32'h0,        32'h0,        0,  1,  1, 32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk("sh_mis",   0,1,0,0,0,1,0, 32'h101, 32'h0,        32'h0,        0,  1,  1, 32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk("sw_mis",   0,1,0,0,0,0,0, 32'h301, 32'h0,        32'h0,        0,  1,  1, 32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk("ill_rw",   1,1,0,0,0,0,0, 32'h100, 32'h0,        32'h0,        0,  1,  1, 32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk("ill_none", 0,0,0,0,0,0,0, 32'h100, 32'h0,        32'h0,        0,  1,  1, 32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk("lw_tmo",   1,0,0,0,0,0,0, 32'h400, 32'h0,        32'h55555555, -1, 17, 1, 32'hDEADBEEF, 16, 0, 32'h0));
        vecs.push_back(mk("sb_tmo",   0,1,0,0,1,0,0, 32'h500, 32'h000000AA, 32'h55555555, -1, 17, 1, 32'hDEADBEEF, 16, 0, 32'h0));
        vecs.push_back(mk("lb_b3",    1,0,1,0,0,0,0, 32'h107, 32'h0,        32'h000000A5, 0,  2,  0, 32'h000000A5, 1, 0, 32'h0));

        // Reset and reset-state checks
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_wr = 1'b0;
        bus.req_lb = 1'b0; bus.req_lh = 1'b0; bus.req_sb = 1'b0; bus.req_sh = 1'b0;
        bus.req_sext = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.done",      32'(bus.done),    32'd0);
        chk("rst.err",       32'(bus.err),     32'd0);
        chk("rst.mem_req",   32'(bus.mem_req), 32'd0);
        chk("rst.mem_we",    32'(bus.mem_we),  32'd0);
        chk("rst.mem_addr",  bus.mem_addr,     32'd0);
        chk("rst.mem_wdata", bus.mem_wdata,    32'd0);
        chk("rst.rdata",     bus.rdata,        32'd0);
        chk("rst.stall",     32'(bus.stall),   32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted while the RMW write is outstanding
        bus.req_rd = 1'b0; bus.req_wr = 1'b1; bus.req_lb = 1'b0; bus.req_lh = 1'b0;
        bus.req_sb = 1'b1; bus.req_sh = 1'b0; bus.req_sext = 1'b0;
        bus.req_addr = 32'h600; bus.req_wdata = 32'h000000AB;
        bus.mem_rdata = 32'h11223344; bus.mem_ack = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rstwr.rd_req", 32'(bus.mem_req), 32'd1);
        chk("rstwr.rd_we",  32'(bus.mem_we),  32'd0);
        bus.mem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rstwr.wr_req",   32'(bus.mem_req), 32'd1);
        chk("rstwr.wr_we",    32'(bus.mem_we),  32'd1);
        chk("rstwr.wr_wdata", bus.mem_wdata,    32'hAB223344);
        bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rstwr.req_drop", 32'(bus.mem_req), 32'd0);
        chk("rstwr.we_drop",  32'(bus.mem_we),  32'd0);
        done_seen = int'(bus.done);
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            done_seen += int'(bus.done);
        end
        chk("rstwr.no_done", 32'(done_seen), 32'd0);
        chk("rstwr.rdata",   bus.rdata,      32'd0);
        run_vec(mk("lw_after_rst", 1,0,0,0,0,0,0, 32'h700, 32'h0, 32'h0BADF00D,
                   1, 3, 0, 32'h0BADF00D, 2, 0, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_dlx_mem_seq
`default_nettype wire
